dmem_resp: RTL and testbench
============================

# dmem_resp

Data-memory responder sitting on the far side of the main control unit's MemRd/MemWr strobes. It accepts one word load or store from the datapath, inserts a configurable number of wait states, and performs the access on an internal word array. It holds the pipeline with Stall until the access completes, then pulses Done with read data. It replaces the zero-latency data memory so the core can be exercised against slow memory.

## Interface
Parameters:
- DEPTH, 256: number of WORD_LEN-bit words; power of two, 4..65536.
- WAIT, 2: extra wait-state cycles per access, 0..15.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- MemRd  in  1  load request; held stable by the requester until Done.
- MemWr  in  1  store request; held stable by the requester until Done.
- Addr  in  WORD_LEN  byte address; sampled at acceptance.
- WrData  in  WORD_LEN  store data; sampled at acceptance.
- RdData  out  WORD_LEN  load result, registered.
- Stall  out  1  combinational pipeline hold.
- Done  out  1  one-cycle completion pulse.
- AddrErr  out  1  misaligned-access flag, valid with Done.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE, with MemRd|MemWr high at an edge:
  - latch op, word index and WrData;
  - load the wait counter with WAIT;
  - go to BUSY.
- BUSY, counter ≠ 0: decrement.
- BUSY, counter = 0: perform the access, then go to DONE.
  - Store: write the array.
  - Load: register the array word into RdData.
- DONE: Done=1 for exactly one cycle, then go to IDLE. Requests are not sampled in DONE. A request still high in the following IDLE cycle starts a new access.
- MemRd and MemWr both high: treated as a store. RdData is not updated.
- Stall = (MemRd|MemWr) & (state ≠ DONE), purely combinational from the inputs and state.
- Word index = Addr[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH words.
- RdData holds its value until the next completed load.
- The array has no reset; contents are undefined until written.
- Reset, including mid-access:
  - state returns to IDLE;
  - a latched store is discarded without writing;
  - RdData=0, Done=0, AddrErr=0;
  - Stall follows its equation (high if a request is present).

## Timing
- A request first seen in IDLE at cycle 0 gives:
  - BUSY in cycles 1..WAIT+1;
  - array write / RdData load at the edge ending cycle WAIT+1;
  - Done=1 in cycle WAIT+2.
- Stall is high in cycles 0..WAIT+1, i.e. WAIT+2 cycles, and low in the Done cycle.
- WAIT=0: Stall in cycles 0–1, Done in cycle 2.
- Back-to-back requests: the next acceptance is no earlier than cycle WAIT+3, so throughput is one access per WAIT+3 cycles.
- A store is visible to a load accepted after its Done.
- Inputs that change between acceptance and Done are ignored; only the latched copies are used.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - Addr[1:0] ≠ 0 at acceptance marks the access misaligned.
  - A misaligned store does not write.
  - A misaligned load sets RdData to 0.
  - AddrErr=1 in the Done cycle of that access only.
  - Timing is unchanged.
- DMEM_ALIGN_CHECK_EN not defined: Addr[1:0] is ignored and AddrErr is tied to 0.

## Structure
- define.v gains the following; WORD_LEN stays the shared width:
  - DMEM_STATE_LEN;
  - state encodings DMEM_IDLE=2'b00, DMEM_BUSY=2'b01, DMEM_DONE=2'b10;
  - the DMEM_ALIGN_CHECK_EN default (undefined).
- One sub-module, dmem_array: a single-port synchronous word RAM, parameterised by DEPTH. It has a write enable and a registered read, with no reset.
- FSM, wait counter and alignment check stay in dmem_resp.

## Test plan
- Reset, then WAIT=2, store 0xDEADBEEF to 0x10, then load 0x10:
  - Stall high 4 cycles per access;
  - Done in cycle 4 of each access;
  - RdData=0xDEADBEEF.
- WAIT=0, load 0x0 right after reset with no prior write:
  - Stall cycles 0–1, Done in cycle 2;
  - RdData stays 0 before Done.
- DEPTH=256: store 0x1 to 0x400 (wraps to word 0), then load 0x0 → RdData=0x1.
- MemRd=MemWr=1 with WrData=0x55, Addr=0x8 → write occurs; RdData unchanged; a later load of 0x8 returns 0x55.
- rst pulsed in cycle 1 of a store of 0xAA to 0x20 → state IDLE, Done never pulses, a later load of 0x20 does not return 0xAA (prefill 0x0 first).
- DMEM_ALIGN_CHECK_EN defined, store to 0x22 → AddrErr=1 and Done=1 in the same cycle, word 8 unchanged; aligned access to 0x20 → AddrErr=0.

Source files
------------

// File: rtl/dmem_resp_pkg.sv
// rtl/dmem_resp_pkg.sv - shared width, FSM encodings and helpers for the data-memory responder
// Optional build macro: DMEM_ALIGN_CHECK_EN (left undefined by default).
// No ports; imported by dmem_resp_if, dmem_array and dmem_resp.
package dmem_resp_pkg;

  localparam int WORD_LEN       = 32;
  localparam int DMEM_STATE_LEN = 2;
  localparam int WAIT_CNT_LEN   = 4;

  typedef enum logic [DMEM_STATE_LEN-1:0] {
    DMEM_IDLE = 2'b00,
    DMEM_BUSY = 2'b01,
    DMEM_DONE = 2'b10
  } dmem_state_e;

  function automatic logic is_misaligned(input logic [1:0] byte_lsb);
    return byte_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// rtl/dmem_resp_if.sv - request/response bundle between the datapath and the data-memory responder
// Signals:
//   MemRd, MemWr   requester -> memory  load / store strobes, held until Done
//   Addr, WrData   requester -> memory  byte address and store data
//   RdData         memory -> requester  registered load result
//   Stall          memory -> requester  pipeline hold
//   Done           memory -> requester  one-cycle completion pulse
//   AddrErr        memory -> requester  misaligned-access flag, valid with Done
// Modports: master (datapath side), slave (memory side).
interface dmem_resp_if;
  import dmem_resp_pkg::*;

  logic                MemRd;
  logic                MemWr;
  logic [WORD_LEN-1:0] Addr;
  logic [WORD_LEN-1:0] WrData;
  logic [WORD_LEN-1:0] RdData;
  logic                Stall;
  logic                Done;
  logic                AddrErr;

  modport master (
    output MemRd, MemWr, Addr, WrData,
    input  RdData, Stall, Done, AddrErr
  );

  modport slave (
    input  MemRd, MemWr, Addr, WrData,
    output RdData, Stall, Done, AddrErr
  );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous word RAM with registered read and no reset
// Ports:
//   clk    in   clock
//   we     in   write enable; writes wdata to addr at the rising edge
//   re     in   read enable; captures the word at addr into rdata at the rising edge
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  read register; holds until the next enabled read
module dmem_array
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WORD_LEN-1:0]      wdata,
  output logic [WORD_LEN-1:0]      rdata
);

  logic [WORD_LEN-1:0] mem [DEPTH];
  logic [WORD_LEN-1:0] rdata_q;
  logic [WORD_LEN-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - wait-state data-memory responder: accepts one load/store, stalls, then pulses Done
// Build option: DMEM_ALIGN_CHECK_EN enables the Addr[1:0] misalignment check and AddrErr.
// Parameters: DEPTH (words, power of two 4..65536), WAIT (extra wait states, 0..15).
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-high reset
//   bus  slave side of dmem_resp_if (MemRd/MemWr/Addr/WrData in; RdData/Stall/Done/AddrErr out)
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  dmem_resp_if.slave  bus
);

  localparam int                      IDX_W     = $clog2(DEPTH);
  localparam logic [WAIT_CNT_LEN-1:0] WAIT_INIT = WAIT_CNT_LEN'(WAIT);

  dmem_state_e             state_q, state_d;
  logic [WAIT_CNT_LEN-1:0] cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic                    mis_q, mis_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [WORD_LEN-1:0]     wdata_q, wdata_d;
  // RdData is forced to zero after reset and after a misaligned load; the
  // RAM read register itself cannot be reset, so this flag masks it.
  logic                    rd_zero_q, rd_zero_d;

  logic                    req;
  logic                    mis_now;
  logic                    ram_we;
  logic                    ram_re;
  logic [WORD_LEN-1:0]     ram_rdata;

  // A request with both strobes high is a store.
  assign req = bus.MemRd | bus.MemWr;

`ifdef DMEM_ALIGN_CHECK_EN
  logic unused_addr;
  assign unused_addr = ^bus.Addr[WORD_LEN-1:IDX_W+2];
  assign mis_now     = is_misaligned(bus.Addr[1:0]);
  assign bus.AddrErr = (state_q == DMEM_DONE) && mis_q;
`else
  logic unused_addr;
  assign unused_addr = ^{bus.Addr[WORD_LEN-1:IDX_W+2], bus.Addr[1:0]};
  assign mis_now     = 1'b0;
  assign bus.AddrErr = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    mis_d     = mis_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    rd_zero_d = rd_zero_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;

    case (state_q)
      DMEM_IDLE: begin
        if (req) begin
          wr_d    = bus.MemWr;
          mis_d   = mis_now;
          idx_d   = bus.Addr[IDX_W+1:2];
          wdata_d = bus.WrData;
          cnt_d   = WAIT_INIT;
          state_d = DMEM_BUSY;
        end
      end
      DMEM_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = DMEM_DONE;
          if (wr_q) begin
            ram_we = !mis_q;
          end else if (mis_q) begin
            rd_zero_d = 1'b1;
          end else begin
            ram_re    = 1'b1;
            rd_zero_d = 1'b0;
          end
        end
      end
      DMEM_DONE: begin
        // Requests are deliberately not sampled here; a held request is
        // picked up in the following IDLE cycle.
        state_d = DMEM_IDLE;
      end
      default: begin
        state_d = DMEM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DMEM_IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      mis_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      rd_zero_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      mis_q     <= mis_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      rd_zero_q <= rd_zero_d;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign bus.Stall  = req && (state_q != DMEM_DONE);
  assign bus.Done   = (state_q == DMEM_DONE);
  assign bus.RdData = rd_zero_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - self-checking bench for dmem_resp (WAIT=2 and WAIT=0 instances)
module tb_dmem_resp;
  import dmem_resp_pkg::*;

  localparam int WT = 2;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_resp_if bus2 ();
  dmem_resp_if bus0 ();

  dmem_resp #(.DEPTH(256), .WAIT(WT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  dmem_resp #(.DEPTH(256), .WAIT(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One access on the WAIT=WT instance; expected results go through the scoreboard.
  task automatic run_access(input vec_t v, input logic [31:0] prev_rd, input string tag);
    exp_t e;
    int   cyc;
    int   stalls;
    bit   held;
    bit   got;
    e.rdata    = v.exp_rd;
    e.err      = v.exp_err;
    e.done_cyc = WT + 2;
    sb.push_back(e);
    @(negedge clk);
    bus2.MemRd  = v.rd;
    bus2.MemWr  = v.wr;
    bus2.Addr   = v.addr;
    bus2.WrData = v.wdata;
    cyc = 0; stalls = 0; held = 1'b1; got = 1'b0;
    while (!got && cyc <= WT + 10) begin
      #1;
      if (bus2.Done) begin
        got = 1'b1;
        e = sb.pop_front();
        check32({tag, " done_cycle"}, 32'(cyc), 32'(e.done_cyc));
        check32({tag, " rdata"}, bus2.RdData, e.rdata);
        check32({tag, " addrerr"}, {31'd0, bus2.AddrErr}, {31'd0, e.err});
        check32({tag, " stall_at_done"}, {31'd0, bus2.Stall}, 32'd0);
      end else begin
        if (bus2.Stall) stalls++;
        if (bus2.RdData !== prev_rd) held = 1'b0;
      end
      if (!got) begin
        @(negedge clk);
        cyc++;
        // Latched copies must be used: scramble the non-strobe inputs.
        if (cyc == 1) begin
          bus2.Addr   = $urandom;
          bus2.WrData = $urandom;
        end
      end
    end
    bus2.MemRd = 1'b0;
    bus2.MemWr = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      void'(sb.pop_front());
      $display("FAIL %s timeout actual=no_done required=done", tag);
    end
    check32({tag, " stall_cycles"}, 32'(stalls), 32'(WT + 2));
    check32({tag, " rdata_held"}, {31'd0, held}, 32'd1);
  endtask

  initial begin
    int          dones;
    int          first_done;
    int          second_done;
    logic [31:0] prev;
    vec_t        v;

    vecs[0]  = '{0, 1, 32'h10,  32'hDEADBEEF, 32'h0,        0};
    vecs[1]  = '{1, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0};
    vecs[2]  = '{0, 1, 32'h400, 32'h1,        32'hDEADBEEF, 0};
    vecs[3]  = '{1, 0, 32'h0,   32'h0,        32'h1,        0};
    vecs[4]  = '{1, 1, 32'h8,   32'h55,       32'h1,        0};
    vecs[5]  = '{1, 0, 32'h8,   32'h0,        32'h55,       0};
    vecs[6]  = '{0, 1, 32'hFFC, 32'h12345678, 32'h55,       0};
    vecs[7]  = '{1, 0, 32'h3FC, 32'h0,        32'h12345678, 0};
    vecs[8]  = '{0, 1, 32'h20,  32'h11,       32'h12345678, 0};
    vecs[9]  = '{0, 1, 32'h22,  32'h99,       32'h12345678, ALIGN};
    vecs[10] = '{1, 0, 32'h20,  32'h0,        ALIGN ? 32'h11 : 32'h99, 0};
    vecs[11] = '{1, 0, 32'h23,  32'h0,        ALIGN ? 32'h0 : 32'h99,  ALIGN};

    rst = 1'b1;
    bus2.MemRd = 1'b0; bus2.MemWr = 1'b0; bus2.Addr = '0; bus2.WrData = '0;
    bus0.MemRd = 1'b0; bus0.MemWr = 1'b0; bus0.Addr = '0; bus0.WrData = '0;
    repeat (2) @(negedge clk);
    #1;
    check32("reset rdata", bus2.RdData, 32'd0);
    check32("reset done", {31'd0, bus2.Done}, 32'd0);
    check32("reset addrerr", {31'd0, bus2.AddrErr}, 32'd0);
    check32("reset stall", {31'd0, bus2.Stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // WAIT=0: load of word 0 straight after reset.
    @(negedge clk);
    bus0.MemRd = 1'b1;
    bus0.Addr  = 32'h0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check32($sformatf("w0 stall c%0d", c), {31'd0, bus0.Stall}, (c < 2) ? 32'd1 : 32'd0);
      check32($sformatf("w0 done c%0d", c), {31'd0, bus0.Done}, (c == 2) ? 32'd1 : 32'd0);
      if (c < 2) begin
        check32($sformatf("w0 rdata c%0d", c), bus0.RdData, 32'd0);
        @(negedge clk);
      end
    end
    bus0.MemRd = 1'b0;

    prev = 32'h0;
    for (int i = 0; i < 12; i++) begin
      run_access(vecs[i], prev, $sformatf("vec%0d", i));
      prev = vecs[i].exp_rd;
    end

    // Back-to-back: a held load is re-accepted in the IDLE cycle after Done.
    @(negedge clk);
    bus2.MemRd = 1'b1;
    bus2.Addr  = 32'h10;
    dones = 0; first_done = -1; second_done = -1;
    for (int c = 0; c < 2 * (WT + 3); c++) begin
      #1;
      if (bus2.Done) begin
        if (dones == 0) first_done = c;
        else if (dones == 1) second_done = c;
        dones++;
        check32($sformatf("b2b rdata c%0d", c), bus2.RdData, 32'hDEADBEEF);
      end
      @(negedge clk);
    end
    bus2.MemRd = 1'b0;
    check32("b2b done_count", 32'(dones), 32'd2);
    check32("b2b first_done", 32'(first_done), 32'(WT + 2));
    check32("b2b second_done", 32'(second_done), 32'(2 * WT + 5));
    repeat (WT + 3) @(negedge clk);

    // Reset in cycle 1 of a store: the store is discarded.
    v = '{0, 1, 32'h20, 32'h0, 32'hDEADBEEF, 0};
    run_access(v, 32'hDEADBEEF, "prefill");
    @(negedge clk);
    bus2.MemWr  = 1'b1;
    bus2.Addr   = 32'h20;
    bus2.WrData = 32'hAA;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check32("midrst done", {31'd0, bus2.Done}, 32'd0);
    check32("midrst rdata", bus2.RdData, 32'd0);
    check32("midrst addrerr", {31'd0, bus2.AddrErr}, 32'd0);
    check32("midrst stall", {31'd0, bus2.Stall}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bus2.MemWr = 1'b0;
    dones = 0;
    repeat (WT + 4) begin
      @(negedge clk);
      #1;
      if (bus2.Done) dones++;
    end
    check32("midrst no_done", 32'(dones), 32'd0);
    v = '{1, 0, 32'h20, 32'h0, 32'h0, 0};
    run_access(v, 32'h0, "after_rst_load");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
